// File: rtl/fpu_result_buffer.sv
// FPU writeback result buffer.
// Each accepted FPU result is tagged with its PC and opcode and classified as an
// IEEE-754 double. It is then queued in a first-word-fall-through FIFO for the
// writeback consumer. The block also keeps sticky exception flags, and it applies
// backpressure through in_ready so that no result is dropped.
module fpu_result_buffer #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3,
    parameter int unsigned PC_W  = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [PC_W-1:0] in_pc,
    input  logic [1:0]      in_op,
    input  logic [63:0]     in_result,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [1:0]      out_op,
    output logic [63:0]     out_result,
    output logic [2:0]      out_class,
    output logic [AW:0]     count,
    output logic [3:0]      status_flags,
    input  logic            clear_flags
);

    // Class encoding stored with each entry
    localparam logic [2:0] CLS_NORMAL = 3'd0;
    localparam logic [2:0] CLS_ZERO   = 3'd1;
    localparam logic [2:0] CLS_SUB    = 3'd2;
    localparam logic [2:0] CLS_INF    = 3'd3;
    localparam logic [2:0] CLS_NAN    = 3'd4;

    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    // Pointer arithmetic relies on natural AW-bit wrap, so DEPTH must be 2**AW
    if (DEPTH < 2 || DEPTH != (1 << AW)) begin : g_param_check
        $error("fpu_result_buffer: DEPTH must be a power of 2 >= 2 and equal 2**AW");
    end

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [1:0]      op;
        logic [63:0]     result;
        logic [2:0]      cls;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          head;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            push;
    logic            pop;
    logic [10:0]     in_exp;
    logic [51:0]     in_frac;
    logic [2:0]      in_class;
    logic [3:0]      flags_next;

    // Handshake is derived from registered occupancy only, so out_ready cannot reach in_ready
    assign in_ready  = (count < FULL_COUNT);
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Classify the incoming result; the sign bit is ignored
    always_comb begin
        in_exp   = in_result[62:52];
        in_frac  = in_result[51:0];
        in_class = CLS_NORMAL;
        if (in_exp == 11'h000) begin
            in_class = (in_frac == '0) ? CLS_ZERO : CLS_SUB;
        end else if (in_exp == 11'h7FF) begin
            in_class = (in_frac == '0) ? CLS_INF : CLS_NAN;
        end
    end

    // Sticky flag next state: a clear drops everything except a bit set by this push
    always_comb begin
        flags_next = clear_flags ? 4'b0000 : status_flags;
        if (push) begin
            case (in_class)
                CLS_ZERO: flags_next[0] = 1'b1;
                CLS_SUB:  flags_next[1] = 1'b1;
                CLS_INF:  flags_next[2] = 1'b1;
                CLS_NAN:  flags_next[3] = 1'b1;
                default:  ;
            endcase
        end
    end

    // Pointers, occupancy and flags; reset discards any push/pop of the same cycle
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            status_flags <= 4'b0000;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            status_flags <= flags_next;
        end
    end

    // Entry storage; contents are not cleared by reset
    always_ff @(posedge clk) begin
        if (reset && push) begin
            mem[wr_ptr] <= {in_pc, in_op, in_result, in_class};
        end
    end

    // Head of queue falls through to the outputs; all zeros while empty
    always_comb begin
        head       = mem[rd_ptr];
        out_pc     = '0;
        out_op     = 2'b00;
        out_result = 64'd0;
        out_class  = CLS_NORMAL;
        if (out_valid) begin
            out_pc     = head.pc;
            out_op     = head.op;
            out_result = head.result;
            out_class  = head.cls;
        end
    end

endmodule

// File: tb/tb_fpu_result_buffer.sv
// Testbench for fpu_result_buffer. It uses a queue-based reference model, a
// classification vector table and directed corner-case sequences.
module tb_fpu_result_buffer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_pc = '0;
    logic [1:0]  in_op = '0;
    logic [63:0] in_result = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_pc;
    logic [1:0]  out_op;
    logic [63:0] out_result;
    logic [2:0]  out_class;
    logic [3:0]  count;
    logic [3:0]  status_flags;
    logic        clear_flags = 1'b0;

    always #5 clk = ~clk;

    fpu_result_buffer #(.DEPTH(8), .AW(3), .PC_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_op        (in_op),
        .in_result    (in_result),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_op       (out_op),
        .out_result   (out_result),
        .out_class    (out_class),
        .count        (count),
        .status_flags (status_flags),
        .clear_flags  (clear_flags)
    );

    typedef struct {
        logic [7:0]  pc;
        logic [1:0]  op;
        logic [63:0] res;
        logic [2:0]  cls;
    } item_t;

    typedef struct {
        logic [63:0] res;
        logic [2:0]  cls;
        logic [3:0]  flags;
    } vec_t;

    item_t      model_q[$];
    item_t      dut_pop[$];
    logic [3:0] m_flags = 4'b0000;
    int         n_checks = 0;
    int         n_fail = 0;

    function automatic logic [2:0] ref_class(input logic [63:0] r);
        if (r[62:52] == 11'd0) return (r[51:0] == 52'd0) ? 3'd1 : 3'd2;
        if (r[62:52] == 11'h7FF) return (r[51:0] == 52'd0) ? 3'd3 : 3'd4;
        return 3'd0;
    endfunction

    function automatic logic [63:0] rand_result();
        logic        s;
        logic [51:0] f;
        logic [10:0] e;
        s = 1'($urandom);
        f = {20'($urandom), 32'($urandom)};
        case ($urandom_range(0, 4))
            0: return {s, 63'd0};
            1: return {s, 11'd0, f | 52'd1};
            2: return {s, 11'h7FF, 52'd0};
            3: return {s, 11'h7FF, f | 52'd1};
            default: begin
                e = 11'($urandom_range(1, 2046));
                return {s, e, f};
            end
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        item_t h;
        h = '{8'd0, 2'd0, 64'd0, 3'd0};
        if (model_q.size() != 0) h = model_q[0];
        check("m_count", 64'(count), 64'(model_q.size()));
        check("m_out_valid", 64'(out_valid), 64'(model_q.size() != 0));
        check("m_in_ready", 64'(in_ready), 64'(model_q.size() < 8));
        check("m_flags", 64'(status_flags), 64'(m_flags));
        check("m_out_pc", 64'(out_pc), 64'(h.pc));
        check("m_out_op", 64'(out_op), 64'(h.op));
        check("m_out_result", out_result, h.res);
        check("m_out_class", 64'(out_class), 64'(h.cls));
    endtask

    // Drive one cycle, advance the reference model, then compare after the edge
    task automatic cycle(input logic v, input logic [7:0] pc, input logic [1:0] op,
                         input logic [63:0] res, input logic ordy, input logic clr,
                         input logic rst_n);
        bit    do_push;
        bit    do_pop;
        item_t it;
        in_valid    = v;
        in_pc       = pc;
        in_op       = op;
        in_result   = res;
        out_ready   = ordy;
        clear_flags = clr;
        reset       = rst_n;
        if (rst_n && out_valid && ordy)
            dut_pop.push_back('{out_pc, out_op, out_result, out_class});
        if (!rst_n) begin
            model_q.delete();
            m_flags = 4'b0000;
        end else begin
            do_push = v && (model_q.size() < 8);
            do_pop  = ordy && (model_q.size() != 0);
            if (do_pop) void'(model_q.pop_front());
            if (clr) m_flags = 4'b0000;
            if (do_push) begin
                it = '{pc, op, res, ref_class(res)};
                model_q.push_back(it);
                if (it.cls != 3'd0) m_flags[it.cls - 1] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic push(input logic [7:0] pc, input logic [63:0] res);
        cycle(1'b1, pc, 2'b00, res, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic pop();
        cycle(1'b0, 8'd0, 2'b00, 64'd0, 1'b1, 1'b0, 1'b1);
    endtask

    vec_t  vecs[8];
    int    sent;
    logic  v_r;
    logic  r_r;
    logic [7:0] exp_pc[4];

    initial begin
        vecs[0] = '{64'h4008000000000000, 3'd0, 4'b0000};
        vecs[1] = '{64'h8000000000000000, 3'd1, 4'b0001};
        vecs[2] = '{64'h000FFFFFFFFFFFFF, 3'd2, 4'b0011};
        vecs[3] = '{64'h7FEFFFFFFFFFFFFF, 3'd0, 4'b0011};
        vecs[4] = '{64'h0010000000000000, 3'd0, 4'b0011};
        vecs[5] = '{64'hFFF0000000000000, 3'd3, 4'b0111};
        vecs[6] = '{64'hFFFFFFFFFFFFFFFF, 3'd4, 4'b1111};
        vecs[7] = '{64'h0000000000000001, 3'd2, 4'b1111};

        // Reset state
        cycle(1'b0, 8'd0, 2'b00, 64'd0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'd0, 2'b00, 64'd0, 1'b0, 1'b0, 1'b0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_result", out_result, 64'd0);

        // Basic add
        push(8'd0, 64'h4008000000000000);
        check("add_valid", 64'(out_valid), 64'd1);
        check("add_result", out_result, 64'h4008000000000000);
        check("add_class", 64'(out_class), 64'd0);
        check("add_count", 64'(count), 64'd1);
        pop();
        check("add_pop_count", 64'(count), 64'd0);
        check("add_pop_result", out_result, 64'd0);
        check("add_pop_pc", 64'(out_pc), 64'd0);

        // Classification table
        for (int i = 0; i < 8; i++) begin
            push(8'(i), vecs[i].res);
            check("tbl_class", 64'(out_class), 64'(vecs[i].cls));
            check("tbl_flags", 64'(status_flags), 64'(vecs[i].flags));
            pop();
        end

        // Classes in order, flags, clear, clear racing a push
        cycle(1'b0, 8'd0, 2'b00, 64'd0, 1'b0, 1'b1, 1'b1);
        check("cf_clear0", 64'(status_flags), 64'd0);
        dut_pop.delete();
        push(8'd1, 64'h0000000000000000);
        push(8'd2, 64'h0000000000000001);
        push(8'd3, 64'h7FF0000000000000);
        push(8'd4, 64'h7FF8000000000000);
        check("cf_flags_all", 64'(status_flags), 64'hF);
        for (int i = 0; i < 4; i++) pop();
        check("cf_npop", 64'(dut_pop.size()), 64'd4);
        for (int i = 0; i < 4 && i < dut_pop.size(); i++) begin
            check("cf_class", 64'(dut_pop[i].cls), 64'(i + 1));
            check("cf_pc", 64'(dut_pop[i].pc), 64'(i + 1));
        end
        cycle(1'b0, 8'd0, 2'b00, 64'd0, 1'b0, 1'b1, 1'b1);
        check("cf_clear", 64'(status_flags), 64'd0);
        push(8'd5, 64'h0000000000000000);
        check("cf_zero_flag", 64'(status_flags), 64'b0001);
        cycle(1'b1, 8'd6, 2'b00, 64'h7FF8000000000000, 1'b0, 1'b1, 1'b1);
        check("cf_clear_push", 64'(status_flags), 64'b1000);
        pop();
        pop();

        // Full and backpressure
        dut_pop.delete();
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 8'(i), 2'b00, 64'(i), 1'b0, 1'b0, 1'b1);
            if (i == 6) check("full_ready7", 64'(in_ready), 64'd1);
            if (i == 7) check("full_ready8", 64'(in_ready), 64'd0);
            if (i == 7) check("full_count8", 64'(count), 64'd8);
        end
        check("full_count_hold", 64'(count), 64'd8);
        cycle(1'b1, 8'h99, 2'b00, 64'd0, 1'b1, 1'b0, 1'b1);
        check("full_pop_nopush", 64'(count), 64'd7);
        check("full_ready_after", 64'(in_ready), 64'd1);
        for (int i = 0; i < 7; i++) pop();
        check("full_npop", 64'(dut_pop.size()), 64'd8);
        for (int i = 0; i < 8 && i < dut_pop.size(); i++)
            check("full_order", 64'(dut_pop[i].pc), 64'(i));

        // Simultaneous push and pop at count 3
        dut_pop.delete();
        push(8'h10, 64'h10);
        push(8'h11, 64'h11);
        push(8'h12, 64'h12);
        check("sim_count3", 64'(count), 64'd3);
        cycle(1'b1, 8'h20, 2'b00, 64'h20, 1'b1, 1'b0, 1'b1);
        check("sim_count_hold", 64'(count), 64'd3);
        for (int i = 0; i < 3; i++) pop();
        exp_pc[0] = 8'h10;
        exp_pc[1] = 8'h11;
        exp_pc[2] = 8'h12;
        exp_pc[3] = 8'h20;
        check("sim_npop", 64'(dut_pop.size()), 64'd4);
        for (int i = 0; i < 4 && i < dut_pop.size(); i++)
            check("sim_order", 64'(dut_pop[i].pc), 64'(exp_pc[i]));

        // Wrap-around with random consumer
        dut_pop.delete();
        sent = 0;
        for (int c = 0; c < 400 && dut_pop.size() < 20; c++) begin
            v_r = (sent < 20);
            r_r = 1'($urandom);
            if (v_r && model_q.size() < 8) begin
                cycle(1'b1, 8'(sent), 2'(sent), $realtobits(real'(sent)), r_r, 1'b0, 1'b1);
                sent++;
            end else begin
                cycle(v_r, 8'(sent), 2'(sent), $realtobits(real'(sent)), r_r, 1'b0, 1'b1);
            end
        end
        check("wrap_done", 64'(dut_pop.size()), 64'd20);
        for (int i = 0; i < 20 && i < dut_pop.size(); i++) begin
            check("wrap_pc", 64'(dut_pop[i].pc), 64'(i));
            check("wrap_result", dut_pop[i].res, $realtobits(real'(i)));
        end

        // Random traffic against the model
        for (int c = 0; c < 400; c++) begin
            cycle($urandom_range(0, 3) != 0, 8'($urandom), 2'($urandom), rand_result(),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 99) != 0);
        end

        // Reset in the middle of operation
        cycle(1'b0, 8'd0, 2'b00, 64'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) push(8'(8'h40 + i), 64'h7FF0000000000000);
        check("rm_count5", 64'(count), 64'd5);
        cycle(1'b1, 8'h77, 2'b00, 64'h0, 1'b1, 1'b0, 1'b0);
        check("rm_count", 64'(count), 64'd0);
        check("rm_valid", 64'(out_valid), 64'd0);
        check("rm_flags", 64'(status_flags), 64'd0);
        check("rm_ready", 64'(in_ready), 64'd1);
        push(8'h33, 64'h3FF0000000000000);
        check("rm_head_pc", 64'(out_pc), 64'h33);
        check("rm_head_count", 64'(count), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
